// File: rtl/wave_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// wave_pkg: shared types and defaults for the waveform capture block
// Rev 1.0
// ---------------------------------------------------------------
package wave_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 9;

  localparam logic TRIG_RISE = 1'b0;
  localparam logic TRIG_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ARM  = 3'd2,
    POST = 3'd3,
    HOLD = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wave_ram.sv
`default_nettype none
// ---------------------------------------------------------------
// wave_ram: simple dual-port sample RAM, registered read port
// Rev 1.0
// ---------------------------------------------------------------
module wave_ram
  import wave_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // No reset on storage or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/wave_capture_buf.sv
`default_nettype none
// ---------------------------------------------------------------
// wave_capture_buf: triggered circular capture, frozen frame for LCD
// Rev 1.0
// ---------------------------------------------------------------
module wave_capture_buf
  import wave_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int POINTS   = 480,
  parameter int PRE_TRIG = 240,
  parameter int AUTO_TO  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_valid,
  input  logic [DATA_W-1:0] trig_line,
  input  logic              trig_edge,
  input  logic              run_stop,
  input  logic              wave_data_req,
  input  logic [ADDR_W-1:0] wave_addr,
  input  logic              wr_over,
  output logic [DATA_W-1:0] wave_data,
  output logic              outrange,
  output logic              frame_ready,
  output logic              trig_auto
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TO_W  = (AUTO_TO > 1) ? $clog2(AUTO_TO + 1) : 1;
  localparam logic [CNT_W-1:0]  PRE_LAST   = CNT_W'(PRE_TRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LAST  = CNT_W'(POINTS - PRE_TRIG - 1);
  localparam logic [CNT_W-1:0]  POINTS_C   = CNT_W'(POINTS);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(AUTO_TO - 1);
  localparam logic [ADDR_W-1:0] PRE_OFFSET = ADDR_W'(PRE_TRIG);
  localparam logic [DATA_W-1:0] MAX_SAMPLE = '1;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] trig_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] prev_sample;
  logic              clip_flag;
  logic              rd_zero;
  logic [DATA_W-1:0] ram_q;

  logic              capturing;
  logic              wr_en;
  logic              clip;
  logic              edge_hit;
  logic              auto_hit;
  logic [ADDR_W-1:0] rd_addr;
  logic              in_range;

  assign capturing = (state == PRE) || (state == ARM) || (state == POST);
  // A run_stop drop discards the sample of that cycle too, protecting the old frame.
  assign wr_en     = capturing && ad_valid && run_stop;
  assign clip      = (ad_data == '0) || (ad_data == MAX_SAMPLE);
  assign edge_hit  = (trig_edge == TRIG_FALL)
                   ? ((prev_sample > trig_line) && (ad_data <= trig_line))
                   : ((prev_sample < trig_line) && (ad_data >= trig_line));
  assign auto_hit  = (AUTO_TO != 0) && (to_cnt == TO_LAST);

  assign rd_addr   = (trig_ptr - PRE_OFFSET) + wave_addr;
  assign in_range  = {1'b0, wave_addr} < POINTS_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      trig_ptr    <= '0;
      cnt         <= '0;
      to_cnt      <= '0;
      prev_sample <= '0;
      clip_flag   <= 1'b0;
      outrange    <= 1'b0;
      frame_ready <= 1'b0;
      trig_auto   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr      <= wr_ptr + 1'b1;
        prev_sample <= ad_data;
        if (clip) clip_flag <= 1'b1;
      end
      case (state)
        IDLE: if (run_stop) begin
          state     <= PRE;
          cnt       <= '0;
          clip_flag <= 1'b0;
        end
        PRE: if (!run_stop) state <= IDLE;
        else if (ad_valid) begin
          if (cnt == PRE_LAST) begin
            state  <= ARM;
            cnt    <= '0;
            to_cnt <= '0;
          end else cnt <= cnt + 1'b1;
        end
        ARM: if (!run_stop) state <= IDLE;
        else if (ad_valid) begin
          if (edge_hit || auto_hit) begin
            trig_ptr  <= wr_ptr;
            trig_auto <= !edge_hit;
            cnt       <= CNT_W'(1);
            state     <= POST;
          end else to_cnt <= to_cnt + 1'b1;
        end
        POST: if (!run_stop) state <= IDLE;
        else if (ad_valid) begin
          if (cnt == POST_LAST) begin
            state       <= HOLD;
            frame_ready <= 1'b1;
            outrange    <= clip_flag || clip;
            clip_flag   <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        HOLD: if (wr_over) begin
          frame_ready <= 1'b0;
          cnt         <= '0;
          state       <= run_stop ? PRE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Out-of-frame reads are flagged alongside the RAM read so both share the 1-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             rd_zero <= 1'b1;
    else if (wave_data_req) rd_zero <= !in_range;
  end

  assign wave_data = rd_zero ? '0 : ram_q;

  wave_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (ad_data),
    .re      (wave_data_req),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_wave_capture_buf.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_wave_capture_buf: directed scoreboard bench for wave_capture_buf
// Rev 1.0
// ---------------------------------------------------------------
module tb_wave_capture_buf;
  import wave_pkg::*;

  localparam int DW = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] ad_data;
  logic          ad_valid;
  logic [DW-1:0] trig_line;
  logic          trig_edge;
  logic          run_stop;
  logic          wave_data_req;
  logic [AW-1:0] wave_addr;
  logic          wr_over;
  logic [DW-1:0] wave_data;
  logic          outrange;
  logic          frame_ready;
  logic          trig_auto;

  always #5 clk = ~clk;

  wave_capture_buf #(
    .DATA_W (DW), .ADDR_W (AW), .POINTS (480), .PRE_TRIG (240), .AUTO_TO (64)
  ) dut (
    .clk (clk), .rst_n (rst_n), .ad_data (ad_data), .ad_valid (ad_valid),
    .trig_line (trig_line), .trig_edge (trig_edge), .run_stop (run_stop),
    .wave_data_req (wave_data_req), .wave_addr (wave_addr), .wr_over (wr_over),
    .wave_data (wave_data), .outrange (outrange), .frame_ready (frame_ready),
    .trig_auto (trig_auto)
  );

  typedef struct {
    int            addr;
    logic [DW-1:0] d;
  } rd_t;

  rd_t  exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic mon_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Read monitor: a request seen at an edge yields data one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      mon_req = wave_data_req;
      #2;
      if (mon_req) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rd_unexpected: got %0d expected none", wave_data);
        end else begin
          rd_t e;
          e = exp_q.pop_front();
          check($sformatf("rd@%0d", e.addr), 32'(wave_data), 32'(e.d));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    ad_data  = d;
    ad_valid = 1'b1;
    tick();
    ad_valid = 1'b0;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] e);
    wave_addr     = AW'(a);
    wave_data_req = 1'b1;
    exp_q.push_back('{a, e});
    tick();
    wave_data_req = 1'b0;
  endtask

  task automatic pulse_wr_over();
    wr_over = 1'b1;
    tick();
    wr_over = 1'b0;
  endtask

  // Rising ramp phased so the 128 crossing is the 29th ARM sample; frame addr a holds (144+a)%256.
  function automatic logic [DW-1:0] ramp(input int i);
    return DW'((116 + i) % 256);
  endfunction

  // Descending 200..50 phased so 100 is the 31st ARM sample.
  function automatic logic [DW-1:0] falls(input int i);
    return DW'(200 - ((i + 132) % 151));
  endfunction

  task automatic run_ramp(input int from, input int upto);
    for (int i = from; i < upto; i++) send(ramp(i));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0; ad_data = '0; ad_valid = 1'b0; trig_line = 8'd128;
    trig_edge = TRIG_RISE; run_stop = 1'b0; wave_data_req = 1'b0;
    wave_addr = '0; wr_over = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wave_data", 32'(wave_data), 0);
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_outrange", 32'(outrange), 0);
    check("rst_trig_auto", 32'(trig_auto), 0);
    rst_n = 1'b1;
    tick();

    // Rising trigger at 128, wr_over pulsed while armed
    run_stop = 1'b1;
    tick();
    run_ramp(0, 250);
    pulse_wr_over();
    check("rise_fr_arm_wrover", 32'(frame_ready), 0);
    run_ramp(250, 507);
    check("rise_fr_before_last", 32'(frame_ready), 0);
    send(ramp(507));
    check("rise_frame_ready", 32'(frame_ready), 1);
    check("rise_trig_auto", 32'(trig_auto), 0);
    check("rise_outrange", 32'(outrange), 1);
    rd(239, 8'd127);
    rd(0, 8'd144);
    rd(240, 8'd128);
    wave_addr = AW'(5);
    tick();
    tick();
    check("rd_hold", 32'(wave_data), 128);

    // Falling trigger at 100; wr_over in HOLD with run_stop=1 restarts
    trig_line = 8'd100;
    trig_edge = TRIG_FALL;
    pulse_wr_over();
    check("fall_fr_after_wrover", 32'(frame_ready), 0);
    for (int i = 0; i < 509; i++) send(falls(i));
    check("fall_fr_before_last", 32'(frame_ready), 0);
    send(falls(509));
    check("fall_frame_ready", 32'(frame_ready), 1);
    check("fall_outrange", 32'(outrange), 0);
    check("fall_trig_auto", 32'(trig_auto), 0);
    rd(240, 8'd100);
    rd(239, 8'd101);
    rd(0, 8'd189);

    // Forced trigger on the 64th ARM sample of a flat signal
    trig_line = 8'd128;
    trig_edge = TRIG_RISE;
    pulse_wr_over();
    repeat (542) send(8'd50);
    check("auto_fr_before_last", 32'(frame_ready), 0);
    send(8'd50);
    check("auto_frame_ready", 32'(frame_ready), 1);
    check("auto_trig_auto", 32'(trig_auto), 1);
    check("auto_outrange", 32'(outrange), 0);
    for (int a = 0; a < 480; a++) rd(a, 8'd50);
    run_stop = 1'b0;
    pulse_wr_over();
    check("auto_fr_to_idle", 32'(frame_ready), 0);

    // Stop in POST: partial frame stays readable, outrange untouched
    run_stop = 1'b1;
    tick();
    run_ramp(0, 278);
    check("stop_trig_auto", 32'(trig_auto), 0);
    run_stop = 1'b0;
    tick();
    check("stop_frame_ready", 32'(frame_ready), 0);
    check("stop_outrange", 32'(outrange), 0);
    rd(240, 8'd128);
    rd(249, 8'd137);

    // Position the write pointer so the trigger lands at 500 and the frame wraps
    run_stop = 1'b1;
    tick();
    repeat (441) send(8'd77);
    run_stop = 1'b0;
    tick();
    run_stop = 1'b1;
    tick();
    run_ramp(0, 508);
    check("wrap_frame_ready", 32'(frame_ready), 1);
    check("wrap_outrange", 32'(outrange), 1);
    check("wrap_trig_auto", 32'(trig_auto), 0);
    rd(0, 8'd144);
    rd(479, 8'd111);
    rd(480, 8'd0);
    rd(271, 8'd159);
    rd(511, 8'd0);
    rd(240, 8'd128);

    // Asynchronous reset in the middle of POST
    pulse_wr_over();
    run_ramp(0, 272);
    check("mid_post_outrange", 32'(outrange), 1);
    check("mid_post_wave_data", 32'(wave_data), 128);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_wave_data", 32'(wave_data), 0);
    check("async_rst_outrange", 32'(outrange), 0);
    check("async_rst_frame_ready", 32'(frame_ready), 0);
    check("async_rst_trig_auto", 32'(trig_auto), 0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL rd_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
